// File: rtl/exu_div_ctrl.sv
// exu_div_ctrl: sequencer wrapped around the iterative 64-bit divider.
// Accepts RV64M DIV/DIVU/REM/REMU(W) ops from issue. Divide-by-zero and signed
// overflow are resolved locally. All other ops are handed to the divider. The
// quotient or remainder is then selected, sign-extended for W ops, and held for
// writeback. A flush that arrives while the divider is busy waits in DRAIN until
// the divider finishes.
module exu_div_ctrl #(
  parameter int BITS_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic              in_is_w,
  input  logic [BITS_W-1:0] in_src1,
  input  logic [BITS_W-1:0] in_src2,
  input  logic [4:0]        in_rd,
  output logic [BITS_W-1:0] div_dividend,
  output logic [BITS_W-1:0] div_divisor,
  output logic              div_valid,
  output logic              divw,
  output logic              div_signed,
  input  logic              div_ready,
  input  logic              div_out_valid,
  input  logic [BITS_W-1:0] quotient,
  input  logic [BITS_W-1:0] remainder,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BITS_W-1:0] out_result,
  output logic [4:0]        out_rd
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [BITS_W-1:0] ALL_ONES = {BITS_W{1'b1}};
  localparam logic [BITS_W-1:0] ALL_ZERO = {BITS_W{1'b0}};
  localparam logic [BITS_W-1:0] MOST_NEG = {1'b1, {(BITS_W-1){1'b0}}};

  // For W ops, keep the low word and replicate bit 31 across the upper bits.
  function automatic logic [BITS_W-1:0] fmt_result(input logic [BITS_W-1:0] val,
                                                   input logic is_w);
    if (is_w) begin
      fmt_result = {{(BITS_W-32){val[31]}}, val[31:0]};
    end else begin
      fmt_result = val;
    end
  endfunction

  logic [2:0]        r_state;
  logic              r_in_ready;
  logic              r_div_valid;
  logic              r_out_valid;
  logic              r_sel_rem;
  logic              r_is_w;
  logic [4:0]        r_rd;
  logic [BITS_W-1:0] r_result;
  logic [BITS_W-1:0] r_div_dividend;
  logic [BITS_W-1:0] r_div_divisor;
  logic              r_divw;
  logic              r_div_signed;

  logic [2:0]        w_next;
  logic              w_accept;
  logic              w_signed;
  logic              w_div_zero;
  logic              w_min_dividend;
  logic              w_neg_one;
  logic              w_special;
  logic [BITS_W-1:0] w_spec_q;
  logic [BITS_W-1:0] w_spec_r;
  logic [BITS_W-1:0] w_spec_res;
  logic [BITS_W-1:0] w_div_res;

  // Classify the offered op and precompute the result of the special cases.
  always_comb begin
    w_accept = (r_state == S_IDLE) && in_valid && !flush;
    w_signed = ~in_op[0];
    if (in_is_w) begin
      w_div_zero     = (in_src2[31:0] == 32'h0000_0000);
      w_min_dividend = (in_src1[31:0] == 32'h8000_0000);
      w_neg_one      = (in_src2[31:0] == 32'hFFFF_FFFF);
    end else begin
      w_div_zero     = (in_src2 == ALL_ZERO);
      w_min_dividend = (in_src1 == MOST_NEG);
      w_neg_one      = (in_src2 == ALL_ONES);
    end
    w_special = w_div_zero || (w_signed && w_min_dividend && w_neg_one);
    // Divide-by-zero gives q=-1 and r=dividend. Overflow gives q=dividend and r=0.
    if (w_div_zero) begin
      w_spec_q = ALL_ONES;
      w_spec_r = in_src1;
    end else begin
      w_spec_q = in_src1;
      w_spec_r = ALL_ZERO;
    end
    if (in_op[1]) begin
      w_spec_res = fmt_result(w_spec_r, in_is_w);
    end else begin
      w_spec_res = fmt_result(w_spec_q, in_is_w);
    end
    if (r_sel_rem) begin
      w_div_res = fmt_result(remainder, r_is_w);
    end else begin
      w_div_res = fmt_result(quotient, r_is_w);
    end
  end

  // Next-state logic, including the flush and drain rules.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_special ? S_DONE : S_REQ;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_REQ: begin
        if (flush) begin
          w_next = div_ready ? S_DRAIN : S_IDLE;
        end else if (div_ready) begin
          w_next = S_WAIT;
        end else begin
          w_next = S_REQ;
        end
      end
      S_WAIT: begin
        if (flush) begin
          w_next = div_out_valid ? S_IDLE : S_DRAIN;
        end else if (div_out_valid) begin
          w_next = S_DONE;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_DONE: begin
        if (flush || out_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_DONE;
        end
      end
      S_DRAIN: begin
        if (div_out_valid) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_DRAIN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Update the state register and the handshake outputs, which are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_div_valid <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == S_IDLE);
      r_div_valid <= (w_next == S_REQ);
      r_out_valid <= (w_next == S_DONE);
    end
  end

  // Latch the op at accept. Load the divider request only for the normal path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_rem      <= 1'b0;
      r_is_w         <= 1'b0;
      r_rd           <= 5'd0;
      r_div_dividend <= ALL_ZERO;
      r_div_divisor  <= ALL_ZERO;
      r_divw         <= 1'b0;
      r_div_signed   <= 1'b0;
    end else if (w_accept) begin
      r_sel_rem <= in_op[1];
      r_is_w    <= in_is_w;
      r_rd      <= in_rd;
      if (!w_special) begin
        r_div_dividend <= in_src1;
        r_div_divisor  <= in_src2;
        r_divw         <= in_is_w;
        r_div_signed   <= w_signed;
      end else begin
        r_div_dividend <= r_div_dividend;
        r_div_divisor  <= r_div_divisor;
        r_divw         <= r_divw;
        r_div_signed   <= r_div_signed;
      end
    end else begin
      r_sel_rem      <= r_sel_rem;
      r_is_w         <= r_is_w;
      r_rd           <= r_rd;
      r_div_dividend <= r_div_dividend;
      r_div_divisor  <= r_div_divisor;
      r_divw         <= r_divw;
      r_div_signed   <= r_div_signed;
    end
  end

  // Capture the writeback value, either from a special-case accept or from a live divider pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= ALL_ZERO;
    end else if (w_accept && w_special) begin
      r_result <= w_spec_res;
    end else if ((r_state == S_WAIT) && div_out_valid && !flush) begin
      r_result <= w_div_res;
    end else begin
      r_result <= r_result;
    end
  end

  assign in_ready     = r_in_ready;
  assign div_valid    = r_div_valid;
  assign out_valid    = r_out_valid;
  assign div_dividend = r_div_dividend;
  assign div_divisor  = r_div_divisor;
  assign divw         = r_divw;
  assign div_signed   = r_div_signed;
  assign out_result   = r_result;
  assign out_rd       = r_rd;

endmodule

// File: tb/tb_exu_div_ctrl.sv
// Testbench for exu_div_ctrl. The bench models the divider itself. A reference
// model computes RV64M divide results with plain arithmetic.
module tb_exu_div_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_is_w;
  logic [1:0]  in_op;
  logic [63:0] in_src1, in_src2, div_dividend, div_divisor, quotient, remainder, out_result;
  logic [4:0]  in_rd, out_rd;
  logic        div_valid, divw, div_signed, div_ready, div_out_valid, out_valid, out_ready;

  int n_cmp = 0;
  int n_fail = 0;

  exu_div_ctrl #(.BITS_W(64)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_is_w(in_is_w),
    .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_valid(div_valid),
    .divw(divw), .div_signed(div_signed), .div_ready(div_ready),
    .div_out_valid(div_out_valid), .quotient(quotient), .remainder(remainder),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: RISC-V divide semantics. The raw q/r are what a divider would return in the low word (W) or full width.
  task automatic model(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] q, output logic [63:0] r, output logic special);
    logic        sgn;
    logic [31:0] a32, b32;
    sgn = !op[0];
    a32 = a[31:0];
    b32 = b[31:0];
    special = 1'b0;
    if (w) begin
      if (b32 == 32'd0) begin
        q = {32'd0, 32'hFFFF_FFFF}; r = {32'd0, a32}; special = 1'b1;
      end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q = {32'd0, a32}; r = 64'd0; special = 1'b1;
      end else if (sgn) begin
        q = {32'd0, 32'($signed(a32) / $signed(b32))};
        r = {32'd0, 32'($signed(a32) % $signed(b32))};
      end else begin
        q = {32'd0, a32 / b32};
        r = {32'd0, a32 % b32};
      end
    end else begin
      if (b == 64'd0) begin
        q = 64'hFFFF_FFFF_FFFF_FFFF; r = a; special = 1'b1;
      end else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        q = a; r = 64'd0; special = 1'b1;
      end else if (sgn) begin
        q = 64'($signed(a) / $signed(b));
        r = 64'($signed(a) % $signed(b));
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endtask

  function automatic logic [63:0] expect_rd(input logic [1:0] op, input logic w,
                                            input logic [63:0] q, input logic [63:0] r);
    logic [63:0] sel;
    sel = op[1] ? r : q;
    return w ? {{32{sel[31]}}, sel[31:0]} : sel;
  endfunction

  // Run one complete op: accept, optional divider exchange, then writeback with back-pressure.
  task automatic run_op(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd, input logic [63:0] exp,
                        input int req_dly, input int lat, input int wb_dly);
    logic [63:0] q, r;
    logic        special;
    model(op, w, a, b, q, r, special);
    chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_op = op; in_is_w = w; in_src1 = a; in_src2 = b; in_rd = rd;
    div_ready = 1'b0;
    cyc();
    in_valid = 1'b0; in_src1 = {$urandom, $urandom}; in_src2 = {$urandom, $urandom}; in_rd = 5'($urandom);
    if (special) begin
      chk("special_div_valid", {63'd0, div_valid}, 64'd0);
    end else begin
      chk("req_div_valid", {63'd0, div_valid}, 64'd1);
      chk("req_dividend", div_dividend, a);
      chk("req_divisor", div_divisor, b);
      chk("req_divw", {63'd0, divw}, {63'd0, w});
      chk("req_signed", {63'd0, div_signed}, {63'd0, !op[0]});
      chk("req_out_valid", {63'd0, out_valid}, 64'd0);
      for (int i = 0; i < req_dly; i++) begin
        cyc();
        chk("req_hold_valid", {63'd0, div_valid}, 64'd1);
      end
      div_ready = 1'b1;
      cyc();
      div_ready = 1'b0;
      chk("wait_div_valid", {63'd0, div_valid}, 64'd0);
      for (int i = 0; i < lat; i++) begin
        cyc();
        chk("wait_out_valid", {63'd0, out_valid}, 64'd0);
      end
      div_out_valid = 1'b1;
      quotient  = w ? {$urandom, q[31:0]} : q;
      remainder = w ? {$urandom, r[31:0]} : r;
      cyc();
      div_out_valid = 1'b0;
      quotient = {$urandom, $urandom}; remainder = {$urandom, $urandom};
    end
    chk("done_out_valid", {63'd0, out_valid}, 64'd1);
    chk("done_result", out_result, exp);
    chk("done_rd", {59'd0, out_rd}, {59'd0, rd});
    for (int i = 0; i < wb_dly; i++) begin
      cyc();
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_result", out_result, exp);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("wb_out_valid", {63'd0, out_valid}, 64'd0);
    chk("wb_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  // Accept a normal-path op and hand it to the divider; returns in WAIT.
  task automatic start_to_wait(input logic [63:0] a, input logic [63:0] b);
    in_valid = 1'b1; in_op = 2'b01; in_is_w = 1'b0; in_src1 = a; in_src2 = b; in_rd = 5'd9;
    cyc();
    in_valid = 1'b0;
    div_ready = 1'b1;
    cyc();
    div_ready = 1'b0;
  endtask

  initial begin
    logic [1:0]  op;
    logic        w, sp;
    logic [63:0] a, b, q, r;
    int          kind;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_is_w = 1'b0;
    in_src1 = 64'd0; in_src2 = 64'd0; in_rd = 5'd0; div_ready = 1'b0;
    div_out_valid = 1'b0; quotient = 64'd0; remainder = 64'd0; out_ready = 1'b0;
    cyc(); cyc();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_div_valid", {63'd0, div_valid}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_dividend", div_dividend, 64'd0);
    chk("rst_divisor", div_divisor, 64'd0);
    chk("rst_divw_signed", {62'd0, divw, div_signed}, 64'd0);
    chk("rst_result", out_result, 64'd0);
    chk("rst_rd", {59'd0, out_rd}, 64'd0);
    rst = 1'b0;
    cyc();

    // Directed cases from the plan, including 5 cycles of writeback back-pressure.
    run_op(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 5'd3, 64'hFFFF_FFFF_FFFF_FFFD, 1, 3, 5);
    run_op(2'b11, 1'b1, 64'hFFFF_FFFF_0000_0007, 64'h0000_0000_8000_0003, 5'd4, 64'd7, 0, 2, 0);
    run_op(2'b01, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'd1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0);
    run_op(2'b01, 1'b0, 64'h0000_0000_0000_1234, 64'd0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1);
    run_op(2'b10, 1'b1, 64'h0000_0001_8000_0000, 64'd0, 5'd7, 64'hFFFF_FFFF_8000_0000, 0, 0, 0);
    run_op(2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd8,
           64'hFFFF_FFFF_8000_0000, 0, 0, 0);
    run_op(2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 64'd0, 0, 0, 2);

    // Flush in WAIT at the third divide cycle, then a second flush while draining.
    start_to_wait(64'd100, 64'd7);
    cyc(); cyc();
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("drain_in_ready", {63'd0, in_ready}, 64'd0);
    chk("drain_out_valid", {63'd0, out_valid}, 64'd0);
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("drain_flush_ignored", {63'd0, in_ready}, 64'd0);
    cyc();
    chk("drain_hold", {62'd0, in_ready, out_valid}, 64'd0);
    div_out_valid = 1'b1; quotient = 64'd14; remainder = 64'd2; cyc(); div_out_valid = 1'b0;
    chk("drain_exit_in_ready", {63'd0, in_ready}, 64'd1);
    chk("drain_exit_out_valid", {63'd0, out_valid}, 64'd0);
    run_op(2'b11, 1'b0, 64'd100, 64'd7, 5'd11, 64'd2, 0, 1, 0);

    // Flush in REQ without a transfer returns to IDLE.
    in_valid = 1'b1; in_op = 2'b00; in_is_w = 1'b0; in_src1 = 64'd50; in_src2 = 64'd5; cyc();
    in_valid = 1'b0;
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("req_flush_in_ready", {63'd0, in_ready}, 64'd1);
    chk("req_flush_div_valid", {63'd0, div_valid}, 64'd0);

    // Flush in REQ together with a transfer must drain.
    in_valid = 1'b1; cyc(); in_valid = 1'b0;
    flush = 1'b1; div_ready = 1'b1; cyc(); flush = 1'b0; div_ready = 1'b0;
    chk("req_xfer_flush_drain", {62'd0, in_ready, div_valid}, 64'd0);
    div_out_valid = 1'b1; cyc(); div_out_valid = 1'b0;
    chk("req_xfer_flush_exit", {62'd0, in_ready, out_valid}, 64'd2);

    // Flush in WAIT in the same cycle as the result pulse discards the result.
    start_to_wait(64'd9, 64'd3);
    flush = 1'b1; div_out_valid = 1'b1; cyc(); flush = 1'b0; div_out_valid = 1'b0;
    chk("wait_flush_pulse", {62'd0, in_ready, out_valid}, 64'd2);

    // Flush in DONE drops the result.
    in_valid = 1'b1; in_op = 2'b01; in_src2 = 64'd0; cyc(); in_valid = 1'b0;
    chk("done_before_flush", {63'd0, out_valid}, 64'd1);
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("done_flush", {62'd0, in_ready, out_valid}, 64'd2);

    // Flush in IDLE blocks the accept.
    in_valid = 1'b1; in_src2 = 64'd3; flush = 1'b1; cyc(); in_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_no_accept", {61'd0, in_ready, div_valid, out_valid}, 64'd4);

    // A stray result pulse in IDLE is ignored.
    div_out_valid = 1'b1; cyc(); div_out_valid = 1'b0;
    chk("stray_pulse", {62'd0, in_ready, out_valid}, 64'd2);

    // Randomised ops checked against the reference model.
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom); w = 1'($urandom);
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      kind = $urandom_range(0, 4);
      case (kind)
        1: b = w ? {$urandom, 32'd0} : 64'd0;
        2: begin
          a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = w ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
        end
        3: begin
          a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 9));
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: ;
      endcase
      model(op, w, a, b, q, r, sp);
      run_op(op, w, a, b, 5'($urandom), expect_rd(op, w, q, r),
             $urandom_range(0, 2), $urandom_range(0, 4), $urandom_range(0, 3));
    end

    // Synchronous reset in WAIT.
    start_to_wait(64'd77, 64'd4);
    cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst_wait_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_wait_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_wait_div_valid", {63'd0, div_valid}, 64'd0);
    chk("rst_wait_dividend", div_dividend, 64'd0);
    run_op(2'b00, 1'b0, 64'd77, 64'd4, 5'd12, 64'd19, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
